// File: rtl/instruction_fetch_unit.sv
// Fetch stage of a single-issue 32-bit MIPS pipeline.
//
// Owns the program counter and presents it to a combinational instruction
// memory. The returned word is captured into the IF/ID register. The stage
// honours hazard stalls, takes branch/jump redirects resolved in ID (squashing
// the wrong-path fetch), and stops on a misaligned or out-of-range PC.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset (highest priority)
//   instruction    word read from instruction memory at pc (same cycle)
//   stall          hazard unit hold request
//   branch_taken   ID: branch in IF/ID resolved taken
//   branch_imm     ID: signed branch offset in words
//   jump           ID: J instruction in IF/ID
//   jump_index     ID: J target field
//   pc             fetch address to instruction memory
//   if_id_instr    captured instruction (0 = NOP when invalid)
//   if_id_pc_plus4 PC+4 of the captured instruction
//   if_id_valid    IF/ID holds a real instruction
//   fetch_fault    sticky; fetch stopped on an illegal PC
//   fetch_count    number of instructions accepted into IF/ID
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic {RUN, FAULT} state_t;

    // Highest word-aligned address that still lies entirely inside memory.
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    state_t             state;
    logic               redirect;
    logic               illegal_pc;
    logic        [31:0] pc_plus4;
    logic        [31:0] jump_target;
    logic        [31:0] branch_target;
    logic signed [31:0] branch_off;

    // Word offset sign-extended and scaled to bytes.
    function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
        return $signed({{14{imm[15]}}, imm, 2'b00});
    endfunction

    always_comb begin
        pc_plus4      = pc + 32'd4;
        // Redirect inputs describe the instruction in IF/ID, so a bubble
        // there cannot redirect.
        redirect      = (jump | branch_taken) & if_id_valid;
        jump_target   = {if_id_pc_plus4[31:28], jump_index, 2'b00};
        branch_off    = branch_offset(branch_imm);
        branch_target = if_id_pc_plus4 + $unsigned(branch_off);
        illegal_pc    = (pc[1:0] != 2'b00) || (pc > LAST_PC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            pc             <= RESET_PC;
            if_id_instr    <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
            fetch_fault    <= 1'b0;
            fetch_count    <= 32'h0;
        end else begin
            case (state)
                RUN: begin
                    if (stall) begin
                        // Hold everything; ID re-presents any redirect later.
                    end else if (redirect) begin
                        // Jump wins over a simultaneous taken branch.
                        pc             <= jump ? jump_target : branch_target;
                        if_id_instr    <= 32'h0;
                        if_id_pc_plus4 <= 32'h0;
                        if_id_valid    <= 1'b0;
                    end else if (illegal_pc) begin
                        state          <= FAULT;
                        fetch_fault    <= 1'b1;
                        if_id_instr    <= 32'h0;
                        if_id_pc_plus4 <= 32'h0;
                        if_id_valid    <= 1'b0;
                    end else begin
                        pc             <= pc_plus4;
                        if_id_instr    <= instruction;
                        if_id_pc_plus4 <= pc_plus4;
                        if_id_valid    <= 1'b1;
                        fetch_count    <= fetch_count + 32'd1;
                    end
                end
                FAULT: begin
                    // Frozen until reset; IF/ID was already squashed on entry.
                    if_id_valid <= 1'b0;
                    fetch_fault <= 1'b1;
                end
                default: state <= FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    // Word-organised model of the 1 KiB instruction memory.
    assign instruction = (pc < 32'd1024) ? mem[pc[9:2]] : 32'hDEAD_BEEF;

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_BYTES(1024)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .instruction   (instruction),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_imm    (branch_imm),
        .jump          (jump),
        .jump_index    (jump_index),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid),
        .fetch_fault   (fetch_fault),
        .fetch_count   (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                            input logic [31:0] e_pc4, input logic e_vld, input logic [31:0] e_cnt);
        chk({tag, ".pc"},    pc,             e_pc);
        chk({tag, ".instr"}, if_id_instr,    e_instr);
        chk({tag, ".pc4"},   if_id_pc_plus4, e_pc4);
        chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, e_vld});
        chk({tag, ".count"}, fetch_count,    e_cnt);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h0001_1020;
        mem[1] = 32'h0042_1022;
        mem[2] = 32'h2042_0010;

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_imm = 16'h0;
        jump = 1'b0; jump_index = 26'h0;
        step(); step();
        chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        chk("reset.fault", {31'h0, fetch_fault}, 32'h0);
        reset = 1'b0;

        // Sequential fetch.
        step(); chk_ifid("fetch0", 32'h4, 32'h0001_1020, 32'h4, 1'b1, 32'd1);
        step(); chk_ifid("fetch1", 32'h8, 32'h0042_1022, 32'h8, 1'b1, 32'd2);

        // Two-cycle stall at pc=8; a redirect presented during stall is ignored.
        stall = 1'b1;
        step(); chk_ifid("stall1", 32'h8, 32'h0042_1022, 32'h8, 1'b1, 32'd2);
        branch_taken = 1'b1; branch_imm = 16'h0010;
        step(); chk_ifid("stall2", 32'h8, 32'h0042_1022, 32'h8, 1'b1, 32'd2);
        stall = 1'b0; branch_taken = 1'b0;
        step(); chk_ifid("release", 32'hC, 32'h2042_0010, 32'hC, 1'b1, 32'd3);

        // Advance to if_id_pc_plus4 = 0x28.
        for (int i = 0; i < 7; i++) step();
        chk_ifid("run28", 32'h28, 32'hA000_0009, 32'h28, 1'b1, 32'd10);

        // Forward branch: 0x28 + 2*4.
        branch_taken = 1'b1; branch_imm = 16'h0002;
        step(); chk_ifid("br_fwd", 32'h30, 32'h0, 32'h0, 1'b0, 32'd10);
        // Bubble in IF/ID: redirect ignored, normal fetch at 0x30.
        branch_imm = 16'hFFFE;
        step(); chk_ifid("br_nov", 32'h34, 32'hA000_000C, 32'h34, 1'b1, 32'd11);
        // Backward branch: 0x34 - 8.
        step(); chk_ifid("br_back", 32'h2C, 32'h0, 32'h0, 1'b0, 32'd11);
        step(); chk_ifid("br_nov2", 32'h30, 32'hA000_000B, 32'h30, 1'b1, 32'd12);

        // Jump with branch also high: jump target {0, 9, 00} = 0x24.
        jump = 1'b1; jump_index = 26'h9; branch_imm = 16'h0040;
        step(); chk_ifid("jmp_pri", 32'h24, 32'h0, 32'h0, 1'b0, 32'd12);
        jump = 1'b0; branch_taken = 1'b0;
        step(); chk_ifid("jmp_tgt", 32'h28, 32'hA000_0009, 32'h28, 1'b1, 32'd13);

        // Jump to the last legal word 0x3FC.
        jump = 1'b1; jump_index = 26'hFF;
        step(); chk_ifid("jmp_last", 32'h3FC, 32'h0, 32'h0, 1'b0, 32'd13);
        jump = 1'b0;
        step(); chk_ifid("last_ok", 32'h400, 32'hA000_00FF, 32'h400, 1'b1, 32'd14);
        chk("last_ok.fault", {31'h0, fetch_fault}, 32'h0);

        // pc=0x400 is out of range -> fault.
        step(); chk_ifid("fault", 32'h400, 32'h0, 32'h0, 1'b0, 32'd14);
        chk("fault.flag", {31'h0, fetch_fault}, 32'h1);
        jump = 1'b1; branch_taken = 1'b1; jump_index = 26'h1;
        step(); chk_ifid("fault_redir", 32'h400, 32'h0, 32'h0, 1'b0, 32'd14);
        jump = 1'b0; branch_taken = 1'b0; stall = 1'b1;
        step(); chk_ifid("fault_stall", 32'h400, 32'h0, 32'h0, 1'b0, 32'd14);
        chk("fault_stall.flag", {31'h0, fetch_fault}, 32'h1);
        stall = 1'b0;

        // Only reset leaves FAULT.
        reset = 1'b1;
        step(); chk_ifid("unfault", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        chk("unfault.flag", {31'h0, fetch_fault}, 32'h0);
        reset = 1'b0;
        step(); chk_ifid("rerun0", 32'h4, 32'h0001_1020, 32'h4, 1'b1, 32'd1);
        step(); chk_ifid("rerun1", 32'h8, 32'h0042_1022, 32'h8, 1'b1, 32'd2);

        // Reset dominates stall and redirect.
        reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_imm = 16'h0004;
        step(); chk_ifid("rst_pri", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        chk("rst_pri.flag", {31'h0, fetch_fault}, 32'h0);
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        step(); chk_ifid("post_rst", 32'h4, 32'h0001_1020, 32'h4, 1'b1, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
